// File: rtl/mdu_divider_pkg.sv
// -----------------------------------------------------------------------------
// mdu_divider_pkg
//  Shared definitions for the EX-stage DIV/DIVU unit.
//  Contents:
//   DIV_WIDTH_DEF  default operand width
//   div_state_e    divider FSM state encodings (DIV_IDLE / DIV_CALC / DIV_DONE)
// -----------------------------------------------------------------------------
package mdu_divider_pkg;

   localparam int DIV_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/mdu_divider_div_step.sv
// -----------------------------------------------------------------------------
// mdu_divider_div_step
//  One radix-2 restoring iteration: shift the next dividend bit into the
//  partial remainder, trial-subtract the divisor, keep the difference when it
//  does not borrow.
//  Ports:
//   rem       in   WIDTH  partial remainder before this step
//   dvd_msb   in   1      dividend bit shifted in this step
//   dvs       in   WIDTH  divisor magnitude
//   rem_next  out  WIDTH  partial remainder after this step
//   q_bit     out  1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module mdu_divider_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   // One extra bit so the shifted remainder never loses its top bit before
   // the compare.
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   assign rem_sh = {rem, dvd_msb};
   assign diff   = rem_sh - {1'b0, dvs};

   // With rem < dvs on entry, diff[WIDTH] is exactly the borrow of the trial
   // subtraction, so it doubles as the (inverted) compare result.
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/mdu_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
//  Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU in EX.
//  result = {remainder, quotient} feeds the {HI,LO} path; busy stalls IF/ID
//  and ID/EX while a divide is in flight.
//  Ports:
//   clk       in   1        clock
//   rst       in   1        synchronous reset, active-low
//   flush     in   1        cancel in-flight op; wins over start
//   start     in   1        request divide (only sampled in IDLE)
//   sign      in   1        1 = DIV, 0 = DIVU
//   dividend  in   WIDTH    RS operand
//   divisor   in   WIDTH    RT operand
//   busy      out  1        stall request (combinational)
//   done      out  1        one-cycle result-valid pulse
//   result    out  2*WIDTH  {remainder, quotient}, held until next completed op
//  Configuration:
//   DIV_EARLY_OUT_EN  when defined, a zero divisor or |dividend| < |divisor|
//                     skips CALC and completes in the cycle after start.
// -----------------------------------------------------------------------------
module mdu_divider
   import mdu_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude of a signed operand; the most negative value maps onto itself,
   // which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                                input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? neg(v) : v;
   endfunction

   div_state_e state_q, state_d;

   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   dvd_q;   // dividend bits shift out the top, quotient bits in the bottom
   logic [WIDTH-1:0]   dvs_q;
   logic               q_neg_q;
   logic               r_neg_q;
   logic               dz_q;
   logic [2*WIDTH-1:0] result_q;

   logic [WIDTH-1:0]   abs_dvd;
   logic [WIDTH-1:0]   abs_dvs;
   logic               dvs_zero;
   logic               early;
   logic [2*WIDTH-1:0] early_res;
   logic [WIDTH-1:0]   rem_nx;
   logic               q_bit;
   logic [WIDTH-1:0]   q_final;
   logic [WIDTH-1:0]   q_fixed;
   logic [WIDTH-1:0]   r_fixed;
   logic               accept;

   assign abs_dvd  = abs_val(dividend, sign);
   assign abs_dvs  = abs_val(divisor, sign);
   assign dvs_zero = (divisor == '0);
   assign accept   = start && !flush;

   // Early-out results coincide with what the full iteration would produce,
   // so the remainder is just the raw dividend.
   assign early_res = {dividend, dvs_zero ? ONES : '0};

`ifdef DIV_EARLY_OUT_EN
   assign early = dvs_zero || (abs_dvd < abs_dvs);
`else
   assign early = 1'b0;
`endif

   mdu_divider_div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem      (rem_q),
      .dvd_msb  (dvd_q[WIDTH-1]),
      .dvs      (dvs_q),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   // Final-iteration quotient is taken straight from the step so the result
   // can be registered on the same edge that enters DONE.
   assign q_final = {dvd_q[WIDTH-2:0], q_bit};

   // A zero divisor leaves the remainder at |dividend|; restoring the
   // dividend's sign makes it equal the raw dividend, and the quotient is
   // forced to all-ones regardless of signs.
   assign q_fixed = dz_q    ? ONES        : (q_neg_q ? neg(q_final) : q_final);
   assign r_fixed = r_neg_q ? neg(rem_nx) : rem_nx;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and control outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (accept) begin
               busy    = 1'b1;
               state_d = early ? DIV_DONE : DIV_CALC;
            end
         end
         DIV_CALC: begin
            busy = 1'b1;
            if (flush) begin
               state_d = DIV_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            done    = !flush;
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   // Operand latch, iteration and result registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (accept) begin
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  dvd_q   <= abs_dvd;
                  dvs_q   <= abs_dvs;
                  q_neg_q <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_q <= sign && dividend[WIDTH-1];
                  dz_q    <= dvs_zero;
                  if (early) begin
                     result_q <= early_res;
                  end
               end
            end
            DIV_CALC: begin
               if (!flush) begin
                  rem_q <= rem_nx;
                  dvd_q <= q_final;
                  if (cnt_q == CNT_LAST) begin
                     cnt_q    <= '0;
                     result_q <= {r_fixed, q_fixed};
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
module tb_mdu_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int LAT = 33;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        eo;
      logic [63:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   mdu_divider #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .start    (start),
      .sign     (sign),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Start an op in cycle 0 (the cycle whose closing edge samples start) and
   // follow it to its done pulse.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int exp_lat, input string nm);
      int done_cyc;
      int busy_bad;
      done_cyc = -1;
      busy_bad = 0;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      sign     = s;
      start    = 1'b1;
      #1;
      if (!busy) busy_bad++;
      for (int c = 1; c <= 45 && done_cyc < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            done_cyc = c;
            if (busy) busy_bad++;
         end else if (c < exp_lat && !busy) begin
            busy_bad++;
         end
      end
      check({nm, "_latency"}, 64'(done_cyc), 64'(exp_lat));
      check({nm, "_result"}, result, exp);
      check({nm, "_busy"}, 64'(busy_bad), 64'd0);
      @(negedge clk);
      check({nm, "_done_width"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int seen;
      int n_done;
      int done_cyc;

      vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, {32'd2,          32'd14},         "divu_100_7"};
      vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, {32'hFFFF_FFFF,  32'hFFFF_FFFD},  "div_m7_2"};
      vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, {32'd1,          32'hFFFF_FFFD},  "div_7_m2"};
      vecs[3]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 1'b0, {32'hFFFF_FFFF,  32'd3},          "div_m7_m2"};
      vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, {32'd0,          32'h8000_0000},  "div_min_m1"};
      vecs[5]  = '{32'd5,          32'd0,          1'b0, 1'b1, {32'd5,          32'hFFFF_FFFF},  "divu_5_0"};
      vecs[6]  = '{32'hFFFF_FFFB,  32'd0,          1'b1, 1'b1, {32'hFFFF_FFFB,  32'hFFFF_FFFF},  "div_m5_0"};
      vecs[7]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, {32'd0,          32'hFFFF_FFFF},  "divu_max_1"};
      vecs[8]  = '{32'hFFFF_FFF0,  32'd16,         1'b0, 1'b0, {32'd0,          32'h0FFF_FFFF},  "divu_big_16"};
      vecs[9]  = '{32'd3,          32'd9,          1'b0, 1'b1, {32'd3,          32'd0},          "divu_3_9"};
      vecs[10] = '{32'hFFFF_FFFD,  32'd9,          1'b1, 1'b1, {32'hFFFF_FFFD,  32'd0},          "div_m3_9"};
      vecs[11] = '{32'd9,          32'd0,          1'b0, 1'b1, {32'd9,          32'hFFFF_FFFF},  "divu_9_0"};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy",   {63'd0, busy}, 64'd0);
      check("reset_done",   {63'd0, done}, 64'd0);
      check("reset_result", result,        64'd0);
      rst = 1'b1;

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp,
                (EO && vecs[i].eo) ? 1 : LAT, vecs[i].name);
      end

      // Flush during CALC at cycle 10, new op at cycle 12
      seen = 0;
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      sign     = 1'b0;
      start    = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) seen = 1;
         if (c == 10) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_busy",   {63'd0, busy}, 64'd0);
      check("flush_done",   64'(seen + int'(done)), 64'd0);
      check("flush_result", result, vecs[11].exp);
      run_op(32'd77, 32'd5, 1'b0, {32'd2, 32'd15}, LAT, "after_flush");

      // start pulsed mid-CALC must not disturb the op in flight
      n_done   = 0;
      done_cyc = -1;
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      sign     = 1'b0;
      start    = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         start = (c == 5);
         if (c == 5) begin
            dividend = 32'd50;
            divisor  = 32'd5;
            sign     = 1'b1;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
      end
      check("restart_done_count", 64'(n_done), 64'd1);
      check("restart_latency",    64'(done_cyc), 64'd33);
      check("restart_result",     result, {32'd2, 32'd14});

      // Reset asserted mid-operation at cycle 20
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      sign     = 1'b0;
      start    = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 20) rst = 1'b0;
      end
      @(negedge clk);
      check("rst_busy",   {63'd0, busy}, 64'd0);
      check("rst_done",   {63'd0, done}, 64'd0);
      check("rst_result", result,        64'd0);
      rst = 1'b1;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      check("rst_quiet", 64'(n_done), 64'd0);
      run_op(32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, LAT, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
